// File: rtl/mul_div_unit_pkg.sv
// Shared ALU definitions: ALUControl op codes and the multiply/divide FSM encoding.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    ALU_MUL   = 4'b0100,
    ALU_UMULL = 4'b0110,
    ALU_DIV   = 4'b0111,
    ALU_SMULL = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative datapath: shift-add multiply or restoring divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // Multiply keeps {hi,lo} as {partial product, remaining multiplier bits};
  // divide keeps {hi,lo} as {partial remainder, dividend/quotient bits}.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh   = {hi, lo[WIDTH-1]};
    diff = sh - {1'b0, m};
    if (is_div) begin
      hi_nxt = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: WIDTH cycles per MUL/UMULL/SMULL/DIV, one-cycle done pulse.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic             is_div, neg;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod, fixed;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .hi     (hi),
    .lo     (lo),
    .m      (mcand),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // SMULL ran on magnitudes; restore the sign on the final 2*WIDTH value.
  always_comb begin
    prod  = {hi_nxt, lo_nxt};
    fixed = neg ? (~prod + 1'b1) : prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      is_div      <= 1'b0;
      neg         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          div_by_zero <= 1'b0;
          cnt         <= '0;
          hi          <= '0;
          case (alu_op_e'(op))
            ALU_MUL, ALU_UMULL: begin
              lo <= a; mcand <= b; is_div <= 1'b0; neg <= 1'b0;
              busy <= 1'b1; state <= S_RUN;
            end
            ALU_SMULL: begin
              lo     <= a[WIDTH-1] ? (~a + 1'b1) : a;
              mcand  <= b[WIDTH-1] ? (~b + 1'b1) : b;
              is_div <= 1'b0;
              neg    <= a[WIDTH-1] ^ b[WIDTH-1];
              busy   <= 1'b1; state <= S_RUN;
            end
            ALU_DIV: begin
              if (b == '0) begin
                result_lo   <= '1;
                result_hi   <= a;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
                state       <= S_DONE;
              end else begin
                lo <= a; mcand <= b; is_div <= 1'b1; neg <= 1'b0;
                busy <= 1'b1; state <= S_RUN;
              end
            end
            default: begin
              result_lo <= '0;
              result_hi <= '0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          endcase
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            result_lo <= fixed[WIDTH-1:0];
            result_hi <= fixed[2*WIDTH-1:WIDTH];
            busy      <= 1'b0;
            done      <= 1'b1;
            cnt       <= '0;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for done; lat counts cycles from the
  // start cycle to the done cycle, bcnt counts cycles with busy high before done.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({busy, done, div_by_zero, result_lo, result_hi} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b lo=%h hi=%h, want all 0",
               busy, done, div_by_zero, result_lo, result_hi);
    end
    reset = 1'b1;
  endtask

  task automatic test_umull();
    int lat, bc;
    run_op(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if (result_hi !== 32'hFFFF_FFFE || result_lo !== 32'h0000_0001) begin
      errors++; $display("FAIL umull_max: got %h_%h, want fffffffe_00000001", result_hi, result_lo);
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL umull_latency: got %0d, want 33", lat); end
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL umull_busy_cycles: got %0d, want 32", bc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done: got %b, want 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result_lo !== 32'h1) begin
      errors++; $display("FAIL done_pulse_hold: got done=%b lo=%h, want done=0 lo=00000001", done, result_lo);
    end
    run_op(4'b0100, 32'd7, 32'd6, lat, bc);
    checks++;
    if (result_hi !== 32'd0 || result_lo !== 32'd42) begin
      errors++; $display("FAIL mul_7x6: got %h_%h, want 00000000_0000002a", result_hi, result_lo);
    end
  endtask

  task automatic test_smull();
    int lat, bc;
    run_op(4'b1000, 32'hFFFF_FFFE, 32'd3, lat, bc);
    checks++;
    if (result_hi !== 32'hFFFF_FFFF || result_lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL smull_m2x3: got %h_%h, want ffffffff_fffffffa", result_hi, result_lo);
    end
    run_op(4'b1000, 32'h8000_0000, 32'h8000_0000, lat, bc);
    checks++;
    if (result_hi !== 32'h4000_0000 || result_lo !== 32'h0) begin
      errors++; $display("FAIL smull_minmin: got %h_%h, want 40000000_00000000", result_hi, result_lo);
    end
    run_op(4'b1000, 32'hFFFF_FFFB, 32'hFFFF_FFF9, lat, bc);
    checks++;
    if (result_hi !== 32'h0 || result_lo !== 32'd35) begin
      errors++; $display("FAIL smull_m5xm7: got %h_%h, want 00000000_00000023", result_hi, result_lo);
    end
  endtask

  task automatic test_div();
    int lat, bc;
    run_op(4'b0111, 32'd100, 32'd7, lat, bc);
    checks++;
    if (result_lo !== 32'd14 || result_hi !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div_100_7: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0",
                         result_lo, result_hi, div_by_zero);
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d, want 33", lat); end
    run_op(4'b0111, 32'd5, 32'd0, lat, bc);
    checks++;
    if (result_lo !== 32'hFFFF_FFFF || result_hi !== 32'd5 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL div_by_zero: got lo=%h hi=%h dbz=%b, want ffffffff 5 1",
                         result_lo, result_hi, div_by_zero);
    end
    checks++;
    if (lat !== 1 || bc !== 0) begin
      errors++; $display("FAIL div0_latency: got lat=%0d busy=%0d, want 1 and 0", lat, bc);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold: got %b, want 1", div_by_zero); end
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h10, lat, bc);
    checks++;
    if (result_lo !== 32'h0FFF_FFFF || result_hi !== 32'hF || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div_big: got q=%h r=%h dbz=%b, want 0fffffff f 0",
                         result_lo, result_hi, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    logic [31:0] lo_s = '1, hi_s = '1;
    @(posedge clk); #1;
    start = 1'b1; op = 4'b0100; a = 32'h0001_0000; b = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (done) begin ndone++; lo_s = result_lo; hi_s = result_hi; end
      @(posedge clk); #1;
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL restart_done_count: got %0d, want 1", ndone); end
    checks++;
    if (lo_s !== 32'h0 || hi_s !== 32'h1) begin
      errors++; $display("FAIL restart_result: got %h_%h, want 00000001_00000000", hi_s, lo_s);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    @(posedge clk); #1;
    start = 1'b1; op = 4'b0111; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, result_lo, result_hi} !== '0) begin
      errors++; $display("FAIL reset_mid_run: got busy=%b done=%b dbz=%b lo=%h hi=%h, want all 0",
                         busy, done, div_by_zero, result_lo, result_hi);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_op(4'b0110, 32'd3, 32'd4, lat, bc);
    checks++;
    if (result_lo !== 32'd12 || result_hi !== 32'd0 || lat !== 33) begin
      errors++; $display("FAIL after_reset_umull: got lo=%0d hi=%0d lat=%0d, want 12 0 33",
                         result_lo, result_hi, lat);
    end
  endtask

  task automatic test_unsupported();
    int lat, bc;
    run_op(4'b0000, 32'h1234, 32'h5678, lat, bc);
    checks++;
    if (result_lo !== 32'h0 || result_hi !== 32'h0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL unsupported_result: got lo=%h hi=%h dbz=%b, want 0 0 0",
                         result_lo, result_hi, div_by_zero);
    end
    checks++;
    if (lat !== 1 || bc !== 0) begin
      errors++; $display("FAIL unsupported_timing: got lat=%0d busy=%0d, want 1 and 0", lat, bc);
    end
  endtask

  initial begin
    test_reset();
    test_umull();
    test_smull();
    test_div();
    test_back_to_back();
    test_reset_mid();
    test_unsupported();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
